bus_memory_responder: RTL and testbench

Memory-side responder for the bus interface unit. It answers the unit's byte-wide bus cycles: it latches the 20-bit physical address computed from segment plus offset, then returns a byte for a read (instruction prefetch into the queue, or operand read) or stores a byte for a write. It runs a T1/T2/Tw/T3/T4 bus-cycle state machine with a configurable number of wait states and a bounded on-chip byte array. The block serves as the bench-side and FPGA-side memory for the interface.

---
 rtl/bus_memory_responder.sv | 137 +++++++++++++
 tb/tb_bus_memory_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_memory_responder.sv
// Memory-side responder for byte-wide bus cycles.
// It runs a T1/T2/Tw/T3/T4 cycle over an on-chip byte array at BASE_ADDR.
module bus_memory_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        RD_WR,
  input  logic [19:0] Direction,
  input  logic [7:0]  Data_In,
  output logic [7:0]  Data_Out,
  output logic        Data_OE,
  output logic        Ready,
  output logic        Busy,
  output logic        Err
);

  localparam int unsigned MEM_BYTES = 1 << DEPTH_LOG2;
  localparam logic [20:0] MEM_LIMIT = 21'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_T4
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [19:0]             addr_q;
  logic                    wr_q;
  logic [7:0]              data_q;
  logic [DEPTH_LOG2-1:0]   offset_q;
  logic                    in_range_q;
  logic [3:0]              wait_cnt;
  logic [19:0]             offset;
  logic [7:0]              mem [MEM_BYTES];

  // Addresses below BASE_ADDR wrap to a large offset and fall out of range.
  assign offset = addr_q - BASE_ADDR;

  // Bus-cycle state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address/type, decode, write-data and wait-counter latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      offset_q   <= '0;
      in_range_q <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Req) begin
            addr_q <= Direction;
            wr_q   <= RD_WR;
          end
        end
        S_T1: begin
          offset_q   <= offset[DEPTH_LOG2-1:0];
          in_range_q <= ({1'b0, offset} < MEM_LIMIT);
        end
        S_T2: begin
          if (wr_q) begin
            data_q <= Data_In;
          end
          wait_cnt <= 4'(WAIT_STATES);
        end
        S_TW: begin
          wait_cnt <= wait_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Byte array: a write commits at the end of T3 only when in range.
  always_ff @(posedge clk) begin
    if (!reset && state == S_T3 && wr_q && in_range_q) begin
      mem[offset_q] <= data_q;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    Data_Out   = '0;
    Data_OE    = 1'b0;
    Ready      = 1'b0;
    Busy       = 1'b1;
    Err        = 1'b0;
    unique case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Req) begin
          state_next = S_T1;
        end
      end
      S_T1: state_next = S_T2;
      S_T2: state_next = (WAIT_STATES == 0) ? S_T3 : S_TW;
      S_TW: begin
        if (wait_cnt <= 4'd1) begin
          state_next = S_T3;
        end
      end
      S_T3: begin
        Ready      = 1'b1;
        Err        = !in_range_q;
        state_next = S_T4;
        if (!wr_q) begin
          Data_OE  = 1'b1;
          Data_Out = in_range_q ? mem[offset_q] : 8'hFF;
        end
      end
      S_T4: state_next = S_IDLE;
      default: begin
        Busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Bench for bus_memory_responder: four instances with different wait-state and
// base-address settings, checked against a physical-address byte model.
module tb_bus_memory_responder;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic             rd_wr;
  logic [19:0]      dir;
  logic [7:0]       din;
  logic [3:0][7:0]  dout;
  logic [3:0]       oe;
  logic [3:0]       ready;
  logic [3:0]       busy;
  logic [3:0]       err;

  int errors = 0;
  int checks = 0;
  int          ws_of   [4];
  logic [19:0] base_of [4];
  logic [7:0]  mdl [int];

  always #5 clk = ~clk;

  bus_memory_responder #(.DEPTH_LOG2(10), .BASE_ADDR(20'h00000), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .Req(req[0]), .RD_WR(rd_wr), .Direction(dir), .Data_In(din),
    .Data_Out(dout[0]), .Data_OE(oe[0]), .Ready(ready[0]), .Busy(busy[0]), .Err(err[0]));

  bus_memory_responder #(.DEPTH_LOG2(10), .BASE_ADDR(20'h00000), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .Req(req[1]), .RD_WR(rd_wr), .Direction(dir), .Data_In(din),
    .Data_Out(dout[1]), .Data_OE(oe[1]), .Ready(ready[1]), .Busy(busy[1]), .Err(err[1]));

  bus_memory_responder #(.DEPTH_LOG2(10), .BASE_ADDR(20'h00000), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .Req(req[2]), .RD_WR(rd_wr), .Direction(dir), .Data_In(din),
    .Data_Out(dout[2]), .Data_OE(oe[2]), .Ready(ready[2]), .Busy(busy[2]), .Err(err[2]));

  bus_memory_responder #(.DEPTH_LOG2(10), .BASE_ADDR(20'h10000), .WAIT_STATES(1)) u_hi (
    .clk(clk), .reset(reset), .Req(req[3]), .RD_WR(rd_wr), .Direction(dir), .Data_In(din),
    .Data_Out(dout[3]), .Data_OE(oe[3]), .Ready(ready[3]), .Busy(busy[3]), .Err(err[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete bus cycle on instance d, with optional extra Req pulses in T2/Tw.
  task automatic bus_cycle(input int d, input logic wr, input logic [19:0] addr,
                           input logic [7:0] wdata, input bit intrude);
    logic [19:0] off;
    bit          inr;
    bit          known;
    int          key;
    int          busy_n;
    int          rdy_n;
    int          ws;
    off    = addr - base_of[d];
    inr    = (off < 20'd1024);
    key    = (d << 20) | int'(addr);
    known  = mdl.exists(key);
    ws     = ws_of[d];
    busy_n = 0;
    rdy_n  = 0;
    @(negedge clk);
    req[d] = 1'b1;
    rd_wr  = wr;
    dir    = addr;
    din    = wdata;
    for (int n = 1; n <= ws + 7; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req[d] = 1'b0;
        rd_wr  = ~wr;
        dir    = 20'($urandom);
      end
      if (intrude && (n == 2 || n == 3)) begin
        req[d] = 1'b1;
        dir    = addr ^ 20'h00123;
      end else if (intrude && n == 4) begin
        req[d] = 1'b0;
      end
      if (n >= 3) din = 8'($urandom);
      if (busy[d]) busy_n++;
      if (ready[d]) begin
        rdy_n++;
        if (rdy_n == 1) begin
          check("latency", n, ws + 3);
          check("err", err[d], !inr);
          check("data_oe", oe[d], !wr);
          if (wr) check("dout_wr", dout[d], 8'h00);
          else if (!inr) check("dout_oor", dout[d], 8'hFF);
          else if (known) check("dout_rd", dout[d], mdl[key]);
        end
      end
      if (n == ws + 4) begin
        check("t4_busy", busy[d], 1'b1);
        check("t4_oe", oe[d], 1'b0);
        check("t4_dout", dout[d], 8'h00);
      end
    end
    check("busy_cycles", busy_n, ws + 4);
    check("ready_pulses", rdy_n, 1);
    if (wr && inr) mdl[key] = wdata;
  endtask

  initial begin
    int k;
    int last;
    ws_of[0] = 1; base_of[0] = 20'h00000;
    ws_of[1] = 0; base_of[1] = 20'h00000;
    ws_of[2] = 3; base_of[2] = 20'h00000;
    ws_of[3] = 1; base_of[3] = 20'h10000;
    reset = 1'b1;
    req   = '0;
    rd_wr = 1'b0;
    dir   = '0;
    din   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 4'h0);
    check("rst_ready", ready, 4'h0);
    check("rst_oe", oe, 4'h0);
    check("rst_err", err, 4'h0);
    check("rst_dout", dout, 32'h0);
    reset = 1'b0;

    // Directed write/read and wait-state latency.
    bus_cycle(0, 1'b1, 20'h00010, 8'hA5, 1'b0);
    bus_cycle(0, 1'b0, 20'h00010, 8'h00, 1'b0);
    bus_cycle(1, 1'b1, 20'h00040, 8'h5C, 1'b0);
    bus_cycle(1, 1'b0, 20'h00040, 8'h00, 1'b0);
    bus_cycle(2, 1'b1, 20'h00041, 8'hC3, 1'b0);
    bus_cycle(2, 1'b0, 20'h00041, 8'h00, 1'b0);

    // Range boundaries on the high-base instance.
    bus_cycle(3, 1'b1, 20'h103FF, 8'h5A, 1'b0);
    bus_cycle(3, 1'b0, 20'h103FF, 8'h00, 1'b0);
    bus_cycle(3, 1'b0, 20'h10400, 8'h00, 1'b0);
    bus_cycle(3, 1'b1, 20'h0FFFF, 8'h3C, 1'b0);
    bus_cycle(3, 1'b0, 20'h103FF, 8'h00, 1'b0);
    bus_cycle(3, 1'b0, 20'h10000, 8'h00, 1'b0);

    // Req pulses during T2 and Tw are ignored.
    bus_cycle(0, 1'b0, 20'h00010, 8'h00, 1'b1);

    // Randomized traffic around each instance's window edges.
    for (int i = 0; i < 60; i++) begin
      int          d;
      logic [19:0] a;
      d = $urandom_range(0, 3);
      a = base_of[d] + 20'($urandom_range(0, 1099)) - 20'd40;
      bus_cycle(d, 1'($urandom_range(0, 1)), a, 8'($urandom), 1'b0);
    end

    // Reset during Tw of a write leaves the old byte in place.
    bus_cycle(0, 1'b1, 20'h00020, 8'h11, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; rd_wr = 1'b1; dir = 20'h00020; din = 8'h77;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy[0], 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_ready", ready[0], 1'b0);
    check("midrst_oe", oe[0], 1'b0);
    check("midrst_err", err[0], 1'b0);
    check("midrst_dout", dout[0], 8'h00);
    reset = 1'b0;
    bus_cycle(0, 1'b0, 20'h00020, 8'h00, 1'b0);

    // Back-to-back prefetch with Req held high.
    for (int i = 0; i < 4; i++) bus_cycle(0, 1'b1, 20'(i), 8'(i + 1), 1'b0);
    @(negedge clk);
    req[0] = 1'b1; rd_wr = 1'b0; dir = 20'h00000;
    k    = 0;
    last = 0;
    for (int t = 1; t <= 40 && k < 4; t++) begin
      @(negedge clk);
      if (ready[0]) begin
        check("b2b_data", dout[0], 8'(k + 1));
        if (k == 0) check("b2b_first", t, 4);
        else check("b2b_gap", t - last, 6);
        last = t;
        k++;
        dir = 20'(k);
        if (k == 4) req[0] = 1'b0;
      end
    end
    check("b2b_count", k, 4);
    repeat (3) @(negedge clk);
    check("b2b_idle", busy[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
